data_mem_ctrl: RTL and testbench

//  Load/store unit between the single-cycle core's data port and a variable-latency data RAM.
//  - Takes the core's word request: ena_rd/ena_wr, byte address, write data and funct3.
//  - Generates byte enables and lane-shifted write data, formats loads with sign/zero extension.
//  - Stalls the core until the RAM acks or a timeout fires; flags misaligned or illegal accesses.

---
 rtl/core_mem_pkg.sv | 27 ++
 rtl/data_mem_ctrl_if.sv | 24 ++
 rtl/lsu_load_format.sv | 29 ++
 rtl/data_mem_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_mem_pkg.sv
// Shared definitions for the core's load/store path: funct3 access codes,
// the LSU state encoding and the alignment rule used by request decode.
package core_mem_pkg;

  // Access size / signedness codes carried in instr[14:12].
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  // Halfwords need an even address, words a 4-byte boundary, bytes go anywhere.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_H, F3_HU: return ~addr_lo[0];
      F3_W:        return (addr_lo == 2'b00);
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Word-wide request/ack bus between the load/store unit and the data RAM.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/lsu_load_format.sv
// Pure combinational load formatter: picks the addressed byte/halfword lane
// out of a RAM word and sign- or zero-extends it to 32 bits.
module lsu_load_format
  import core_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_val
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select followed by extension chosen by funct3.
  always_comb begin
    byte_v = word[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_val = {{24{byte_v[7]}}, byte_v};
      F3_H:    load_val = {{16{half_v[15]}}, half_v};
      F3_W:    load_val = word;
      F3_BU:   load_val = {24'h0, byte_v};
      F3_HU:   load_val = {16'h0, half_v};
      default: load_val = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store unit: decodes the core's data request, drives a variable-latency
// RAM with lane-aligned stores, formats loads and stalls the core until the
// RAM acks or the timeout aborts the access.
module data_mem_ctrl
  import core_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              CLOCK,
  input  logic              RST_n,
  input  logic              ena_rd,
  input  logic              ena_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [2:0]        funct3,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              mem_err,
  data_mem_ctrl_if.master   mem
);

  localparam int             CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-3:0] maddr_q, maddr_d;
  logic [31:0]       mwdata_q, mwdata_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;

  logic              req_any;
  logic              f3_legal;
  logic              req_valid;
  logic [3:0]        new_be;
  logic [31:0]       new_wdata;
  logic [31:0]       load_val;
  logic              stall_c;
  logic              req_c;

  // Request decode: legality, alignment, byte enables and store lane replication.
  always_comb begin
    req_any  = ena_rd | ena_wr;
    f3_legal = 1'b0;
    if (ena_rd) begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_legal = 1'b1;
        default:                        f3_legal = 1'b0;
      endcase
    end else if (ena_wr) begin
      case (funct3)
        F3_B, F3_H, F3_W: f3_legal = 1'b1;
        default:          f3_legal = 1'b0;
      endcase
    end
    req_valid = (ena_rd ^ ena_wr) & f3_legal & is_aligned(funct3, addr[1:0]);

    case (funct3)
      F3_B: begin
        new_be    = 4'b0001 << addr[1:0];
        new_wdata = {4{wdata[7:0]}};
      end
      F3_H: begin
        new_be    = addr[1] ? 4'b1100 : 4'b0011;
        new_wdata = {2{wdata[15:0]}};
      end
      default: begin
        new_be    = 4'b1111;
        new_wdata = wdata;
      end
    endcase
    // Loads always fetch the whole word and pick the lane on the way back.
    if (!ena_wr) new_be = 4'b1111;
  end

  lsu_load_format u_load_format (
    .word     (mem.mem_rdata),
    .addr_lo  (off_q),
    .funct3   (f3_q),
    .load_val (load_val)
  );

  // FSM next state, timeout counter and register updates.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    we_d     = we_q;
    be_d     = be_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    off_d    = off_q;
    f3_d     = f3_q;
    stall_c  = 1'b0;
    req_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_any) begin
          stall_c = 1'b1;
          if (req_valid) begin
            state_d  = ACCESS;
            cnt_d    = '0;
            we_d     = ena_wr;
            be_d     = new_be;
            maddr_d  = addr[ADDR_W-1:2];
            mwdata_d = new_wdata;
            off_d    = addr[1:0];
            f3_d     = funct3;
          end else begin
            state_d = DONE;
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        // An ack in the last allowed cycle still completes normally.
        if (mem.mem_ack) begin
          if (!we_q) rdata_d = load_val;
          state_d = DONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        // The core retires here; its request is still visible but must not reissue.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      maddr_q  <= '0;
      mwdata_q <= 32'h0;
      off_q    <= 2'b00;
      f3_q     <= 3'b000;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      we_q     <= we_d;
      be_q     <= be_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      off_q    <= off_d;
      f3_q     <= f3_d;
    end
  end

  // The core sits in reset alongside us, so never stall it while RST_n is low.
  assign stall         = stall_c & RST_n;
  assign rdata         = rdata_q;
  assign mem_err       = err_q;
  assign mem.mem_req   = req_c;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = mwdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed core requests push expected
// responses; a monitor pops them at each retire cycle and compares.
module tb_data_mem_ctrl;
  import core_mem_pkg::*;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          stall_cyc;
    int          req_cyc;
    logic        chk;
    logic [29:0] maddr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] mwd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena_rd, ena_wr;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        stall, mem_err;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];

  int          ram_lat;
  logic [31:0] ram_word;
  logic        late_ack;
  int          ram_age;

  data_mem_ctrl_if #(.ADDR_W(32)) mif ();

  data_mem_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(16)) dut (
    .CLOCK   (clk),
    .RST_n   (rst_n),
    .ena_rd  (ena_rd),
    .ena_wr  (ena_wr),
    .addr    (addr),
    .wdata   (wdata),
    .funct3  (funct3),
    .rdata   (rdata),
    .stall   (stall),
    .mem_err (mem_err),
    .mem     (mif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [31:0] rd, input logic err,
                              input int st, input int rq, input logic chk,
                              input logic [29:0] ma, input logic [3:0] be,
                              input logic we, input logic [31:0] mwd);
    exp_t e;
    e.id = id; e.rdata = rd; e.err = err; e.stall_cyc = st; e.req_cyc = rq;
    e.chk = chk; e.maddr = ma; e.be = be; e.we = we; e.mwd = mwd;
    return e;
  endfunction

  // RAM model: acks after ram_lat cycles of mem_req (-1 = never).
  always @(posedge clk) begin
    #1;
    if (mif.mem_req && rst_n) begin
      mif.mem_ack = (ram_age == ram_lat);
      ram_age++;
    end else begin
      ram_age     = 0;
      mif.mem_ack = late_ack;
    end
    mif.mem_rdata = ram_word;
  end

  // Monitor: counts stall/req/err cycles per request, compares at retire.
  int          st_cnt, rq_cnt, er_cnt;
  logic        seen_req;
  logic [29:0] cap_addr;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic [31:0] cap_wd;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      st_cnt = 0; rq_cnt = 0; er_cnt = 0; seen_req = 1'b0;
    end else if (ena_rd || ena_wr) begin
      if (mem_err) er_cnt++;
      if (stall) begin
        st_cnt++;
        if (mif.mem_req) begin
          if (!seen_req) begin
            cap_addr = mif.mem_addr; cap_be = mif.mem_be;
            cap_we   = mif.mem_we;   cap_wd = mif.mem_wdata;
          end
          seen_req = 1'b1;
          rq_cnt++;
        end
      end else begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("t%0d_rdata", mon_e.id), rdata, mon_e.rdata);
          check($sformatf("t%0d_err_cycles", mon_e.id), 32'(er_cnt), 32'(mon_e.err));
          check($sformatf("t%0d_stall_cycles", mon_e.id), 32'(st_cnt), 32'(mon_e.stall_cyc));
          check($sformatf("t%0d_req_cycles", mon_e.id), 32'(rq_cnt), 32'(mon_e.req_cyc));
          if (mon_e.chk) begin
            check($sformatf("t%0d_mem_addr", mon_e.id), 32'(cap_addr), 32'(mon_e.maddr));
            check($sformatf("t%0d_mem_be", mon_e.id), 32'(cap_be), 32'(mon_e.be));
            check($sformatf("t%0d_mem_we", mon_e.id), 32'(cap_we), 32'(mon_e.we));
            if (mon_e.we) check($sformatf("t%0d_mem_wdata", mon_e.id), cap_wd, mon_e.mwd);
          end
        end
        st_cnt = 0; rq_cnt = 0; er_cnt = 0; seen_req = 1'b0;
      end
    end
  end

  // Core model: present a request, hold it until retire, then drop it.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3,
                       input int lat, input logic [31:0] word, input exp_t e);
    logic done;
    @(posedge clk); #1;
    ram_lat = lat; ram_word = word;
    exp_q.push_back(e);
    ena_rd = rd; ena_wr = wr; addr = a; wdata = wd; funct3 = f3;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) check($sformatf("t%0d_retire_timeout", e.id), 32'd0, 32'd1);
    @(posedge clk); #1;
    ena_rd = 1'b0; ena_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ena_rd = 1'b0; ena_wr = 1'b0; addr = '0; wdata = '0; funct3 = '0;
    ram_lat = -1; ram_word = '0; late_ack = 1'b0; ram_age = 0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;

    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", 32'(mem_err), 32'd0);
    check("rst_req", 32'(mif.mem_req), 32'd0);
    check("rst_we", 32'(mif.mem_we), 32'd0);
    check("rst_be", 32'(mif.mem_be), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Loads: word, sign/zero-extended bytes and halfwords.
    issue(1, 0, 32'h100, 0, F3_W,  3,  32'hDEADBEEF, mk(1,  32'hDEADBEEF, 0, 5, 4, 1, 30'h40, 4'hF, 0, 0));
    issue(1, 0, 32'h103, 0, F3_B,  0,  32'h80FF0000, mk(2,  32'hFFFFFF80, 0, 2, 1, 1, 30'h40, 4'hF, 0, 0));
    issue(1, 0, 32'h103, 0, F3_BU, 0,  32'h80FF0000, mk(3,  32'h00000080, 0, 2, 1, 1, 30'h40, 4'hF, 0, 0));
    issue(1, 0, 32'h102, 0, F3_H,  1,  32'h80FF0000, mk(4,  32'hFFFF80FF, 0, 3, 2, 1, 30'h40, 4'hF, 0, 0));
    issue(1, 0, 32'h102, 0, F3_HU, 1,  32'h80FF0000, mk(5,  32'h000080FF, 0, 3, 2, 1, 30'h40, 4'hF, 0, 0));
    issue(1, 0, 32'h101, 0, F3_B,  2,  32'h00007F00, mk(6,  32'h0000007F, 0, 4, 3, 1, 30'h40, 4'hF, 0, 0));
    // Stores: lane replication and byte enables; rdata keeps the last load.
    issue(0, 1, 32'h202, 32'h1234ABCD, F3_H, 1, 0, mk(7,  32'h0000007F, 0, 3, 2, 1, 30'h80, 4'hC, 1, 32'hABCDABCD));
    issue(0, 1, 32'h201, 32'h00000077, F3_B, 0, 0, mk(8,  32'h0000007F, 0, 2, 1, 1, 30'h80, 4'h2, 1, 32'h77777777));
    issue(0, 1, 32'h204, 32'hCAFEF00D, F3_W, 2, 0, mk(9,  32'h0000007F, 0, 4, 3, 1, 30'h81, 4'hF, 1, 32'hCAFEF00D));
    // Illegal requests: no RAM access, one-cycle stall, error in retire cycle.
    issue(1, 0, 32'h101, 0, F3_W,   0, 0, mk(10, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0));
    issue(0, 1, 32'h003, 0, F3_H,   0, 0, mk(11, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0));
    issue(1, 1, 32'h100, 0, F3_W,   0, 0, mk(12, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0));
    issue(1, 0, 32'h100, 0, 3'b011, 0, 0, mk(13, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0));
    issue(0, 1, 32'h100, 0, F3_BU,  0, 0, mk(14, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0));
    // Timeout boundary: ack in the 16th request cycle wins, no ack aborts.
    issue(1, 0, 32'h10C, 0, F3_W, 15, 32'h55AA55AA, mk(15, 32'h55AA55AA, 0, 17, 16, 1, 30'h43, 4'hF, 0, 0));
    issue(1, 0, 32'h108, 0, F3_W, -1, 32'h12345678, mk(16, 32'h0, 1, 17, 16, 1, 30'h42, 4'hF, 0, 0));
    issue(1, 0, 32'h110, 0, F3_W, 0,  32'h0BADF00D, mk(17, 32'h0BADF00D, 0, 2, 1, 1, 30'h44, 4'hF, 0, 0));

    // Reset in the middle of an access, then a stray ack.
    @(posedge clk); #1;
    ram_lat = -1; ena_rd = 1'b1; addr = 32'h114; funct3 = F3_W;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_req_before", 32'(mif.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(mif.mem_req), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    ena_rd = 1'b0;
    @(negedge clk);
    check("rst_mid_rdata", rdata, 32'h0);
    check("rst_mid_be", 32'(mif.mem_be), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk) late_ack = 1'b1;
    @(negedge clk) late_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("late_ack_req_%0d", i), 32'(mif.mem_req), 32'd0);
      check($sformatf("late_ack_stall_%0d", i), 32'(stall), 32'd0);
      check($sformatf("late_ack_err_%0d", i), 32'(mem_err), 32'd0);
      check($sformatf("late_ack_rdata_%0d", i), rdata, 32'h0);
    end

    issue(1, 0, 32'h120, 0, F3_W, 2, 32'h0BADF00D, mk(18, 32'h0BADF00D, 0, 4, 3, 1, 30'h48, 4'hF, 0, 0));

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
